alu_arbiter: RTL and testbench

//  - Shares one 32-bit ALU (8 commands: ADD SUB XOR SLT AND NAND NOR OR, 3-bit) between two requesters.
//  - Each requester has a valid/ready request channel. One response channel returns results, tagged with the requester id.
//  - Latches the winning request's operands and command and holds them stable on the ALU for SETTLE_CYCLES.
//  - Then captures result, carryout, zero and overflow into a one-entry response buffer.
//  - Sits between the decode/issue logic and the gate-level ALU, which it instantiates internally.

---
 rtl/alu_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit ALU between two valid/ready requesters with a one-entry tagged response buffer.
// Build option ALU_ARB_FIXED_PRIO_EN: requester 0 always wins contention and no round-robin pointer is built.

module alu_arbiter_alu (
  input  logic [2:0]  command,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] result,
  output logic        carryout,
  output logic        zero,
  output logic        overflow
);
  localparam logic [2:0] COMMAND_ADD  = 3'd0;
  localparam logic [2:0] COMMAND_SUB  = 3'd1;
  localparam logic [2:0] COMMAND_XOR  = 3'd2;
  localparam logic [2:0] COMMAND_SLT  = 3'd3;
  localparam logic [2:0] COMMAND_AND  = 3'd4;
  localparam logic [2:0] COMMAND_NAND = 3'd5;
  localparam logic [2:0] COMMAND_NOR  = 3'd6;
  localparam logic [2:0] COMMAND_OR   = 3'd7;

  logic        is_sub;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        sum_ovf;

  // SUB and SLT share the adder as A + ~B + 1
  assign is_sub  = (command == COMMAND_SUB) || (command == COMMAND_SLT);
  assign b_eff   = is_sub ? ~operand_b : operand_b;
  assign sum     = {1'b0, operand_a} + {1'b0, b_eff} + {32'd0, is_sub};
  assign sum_ovf = (operand_a[31] == b_eff[31]) && (sum[31] != operand_a[31]);

  always_comb begin
    result   = '0;
    carryout = 1'b0;
    overflow = 1'b0;
    case (command)
      COMMAND_ADD, COMMAND_SUB: begin
        result   = sum[31:0];
        carryout = sum[32];
        overflow = sum_ovf;
      end
      COMMAND_XOR:  result = operand_a ^ operand_b;
      COMMAND_SLT:  result = {31'd0, sum[31] ^ sum_ovf};
      COMMAND_AND:  result = operand_a & operand_b;
      COMMAND_NAND: result = ~(operand_a & operand_b);
      COMMAND_NOR:  result = ~(operand_a | operand_b);
      COMMAND_OR:   result = operand_a | operand_b;
      default:      result = '0;
    endcase
    zero = (result == '0);
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid0,
  output logic             ready0,
  input  logic [2:0]       command0,
  input  logic [WIDTH-1:0] operandA0,
  input  logic [WIDTH-1:0] operandB0,
  input  logic             valid1,
  output logic             ready1,
  input  logic [2:0]       command1,
  input  logic [WIDTH-1:0] operandA1,
  input  logic [WIDTH-1:0] operandB1,
  output logic             respValid,
  input  logic             respReady,
  output logic             respId,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [4:0] SETTLE_LOAD = 5'(SETTLE_CYCLES - 1);

  logic [1:0]       state_reg, state_next;
  logic [4:0]       count_reg;
  logic [2:0]       command_reg;
  logic [WIDTH-1:0] operand_a_reg, operand_b_reg;
  logic             id_reg;
  logic             resp_id_reg, carry_reg, zero_reg, overflow_reg;
  logic [WIDTH-1:0] result_reg;
  logic             grant_en, grant0, grant1, grant_any, settled;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry, alu_zero, alu_overflow;

  alu_arbiter_alu alu (
    .command   (command_reg),
    .operand_a (operand_a_reg),
    .operand_b (operand_b_reg),
    .result    (alu_result),
    .carryout  (alu_carry),
    .zero      (alu_zero),
    .overflow  (alu_overflow)
  );

  assign grant_en = !reset && ((state_reg == IDLE) || ((state_reg == DONE) && respReady));

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant1 = grant_en && valid1 && !valid0;
`else
  logic last_grant_reg;
  // On contention the requester that did not win last time is served
  assign grant1 = grant_en && valid1 && (!valid0 || !last_grant_reg);

  always_ff @(posedge clk) begin
    if (reset)
      last_grant_reg <= 1'b1;
    else if (grant_any)
      last_grant_reg <= grant1;
  end
`endif

  assign grant0    = grant_en && valid0 && !grant1;
  assign grant_any = grant0 || grant1;
  assign ready0    = grant0;
  assign ready1    = grant1;

  // The counter runs one step past zero (borrow into bit 4), giving SETTLE_CYCLES+1 edges to capture
  assign settled = count_reg[4];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = EXEC;
      EXEC:    if (settled) state_next = DONE;
      DONE: begin
        if (grant_any)      state_next = EXEC;
        else if (respReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= 5'd1;
      command_reg   <= '0;
      operand_a_reg <= '0;
      operand_b_reg <= '0;
      id_reg        <= 1'b0;
      resp_id_reg   <= 1'b0;
      result_reg    <= '0;
      carry_reg     <= 1'b0;
      zero_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_any) begin
        command_reg   <= grant1 ? command1  : command0;
        operand_a_reg <= grant1 ? operandA1 : operandA0;
        operand_b_reg <= grant1 ? operandB1 : operandB0;
        id_reg        <= grant1;
        count_reg     <= SETTLE_LOAD;
      end else if (state_reg == EXEC) begin
        if (settled) begin
          resp_id_reg  <= id_reg;
          result_reg   <= alu_result;
          carry_reg    <= alu_carry;
          zero_reg     <= alu_zero;
          overflow_reg <= alu_overflow;
        end else begin
          count_reg <= count_reg - 5'd1;
        end
      end
    end
  end

  assign respValid = (state_reg == DONE);
  assign respId    = resp_id_reg;
  assign result    = result_reg;
  assign carryout  = carry_reg;
  assign zero      = zero_reg;
  assign overflow  = overflow_reg;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: per-requester request queues, an arithmetic ALU model and a
// cycle-count response model; honours ALU_ARB_FIXED_PRIO_EN for the expected arbitration order.

module tb_alu_arbiter;
  localparam int S = 2;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  typedef struct packed {
    logic        id;
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        o;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic        ready0, ready1;
  logic [2:0]  command0 = '0, command1 = '0;
  logic [31:0] operandA0 = '0, operandB0 = '0, operandA1 = '0, operandB1 = '0;
  logic        respValid, respReady = 1'b0, respId;
  logic [31:0] result;
  logic        carryout, zero, overflow;

  alu_arbiter #(.WIDTH(32), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .valid0(valid0), .ready0(ready0), .command0(command0), .operandA0(operandA0), .operandB0(operandB0),
    .valid1(valid1), .ready1(ready1), .command1(command1), .operandA1(operandA1), .operandB1(operandB1),
    .respValid(respValid), .respReady(respReady), .respId(respId),
    .result(result), .carryout(carryout), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  req_t  q0[$];
  req_t  q1[$];
  logic  glog[$];
  logic  rr = 1'b1;
  // model of the shared unit: one op in flight, a response visible until taken
  logic  busy = 1'b0, shown = 1'b0, last_id = 1'b1;
  int    cnt = 0;
  resp_t infl = '0, last_resp = '0;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic resp_t ref_alu(input logic id, input req_t q);
    resp_t             p;
    longint            sa, sb, s;
    longint unsigned   u;
    sa = $signed(q.a);
    sb = $signed(q.b);
    p = '0;
    p.id = id;
    case (q.cmd)
      3'd0: begin
        p.r = q.a + q.b;
        u = 64'(q.a) + 64'(q.b);
        p.c = u[32];
        s = sa + sb;
        p.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        p.r = q.a - q.b;
        p.c = (q.a >= q.b);
        s = sa - sb;
        p.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: p.r = q.a ^ q.b;
      3'd3: p.r = (sa < sb) ? 32'd1 : 32'd0;
      3'd4: p.r = q.a & q.b;
      3'd5: p.r = ~(q.a & q.b);
      3'd6: p.r = ~(q.a | q.b);
      default: p.r = q.a | q.b;
    endcase
    p.z = (p.r == 32'd0);
    return p;
  endfunction

  task automatic drive();
    valid0 = (q0.size() > 0);
    valid1 = (q1.size() > 0);
    if (valid0) begin command0 = q0[0].cmd; operandA0 = q0[0].a; operandB0 = q0[0].b; end
    if (valid1) begin command1 = q1[0].cmd; operandA1 = q1[0].a; operandB1 = q1[0].b; end
    respReady = rr;
  endtask

  task automatic step();
    logic ge, g0, g1, v0, v1;
    req_t r;
    @(negedge clk);
    v0 = (q0.size() > 0);
    v1 = (q1.size() > 0);
    ge = !reset && ((!busy && !shown) || (shown && respReady));
`ifdef ALU_ARB_FIXED_PRIO_EN
    g1 = ge && v1 && !v0;
`else
    g1 = ge && v1 && (!v0 || (last_id == 1'b0));
`endif
    g0 = ge && v0 && !g1;
    chk("ready0", {31'd0, ready0}, {31'd0, g0});
    chk("ready1", {31'd0, ready1}, {31'd0, g1});
    if (!reset) begin
      chk("respValid", {31'd0, respValid}, {31'd0, shown});
      chk("respId",    {31'd0, respId},    {31'd0, last_resp.id});
      chk("result",    result,             last_resp.r);
      chk("carryout",  {31'd0, carryout},  {31'd0, last_resp.c});
      chk("zero",      {31'd0, zero},      {31'd0, last_resp.z});
      chk("overflow",  {31'd0, overflow},  {31'd0, last_resp.o});
    end
    if (ready0) glog.push_back(1'b0);
    if (ready1) glog.push_back(1'b1);
    @(posedge clk);
    if (reset) begin
      busy = 1'b0; shown = 1'b0; last_resp = '0; last_id = 1'b1; cnt = 0;
    end else begin
      if (shown && respReady) shown = 1'b0;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin busy = 1'b0; shown = 1'b1; last_resp = infl; end
      end
      if (g0 || g1) begin
        r = g1 ? q1.pop_front() : q0.pop_front();
        infl = ref_alu(g1, r);
        busy = 1'b1;
        cnt = S + 1;
        last_id = g1;
      end
    end
    #1;
    drive();
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((busy || shown || q0.size() > 0 || q1.size() > 0) && n < limit) begin
      step();
      n++;
    end
    chk("drain_within_budget", {31'd0, n < limit}, 32'd1);
  endtask

  task automatic chk_order(input string tag, input logic exp[$]);
    chk({tag, "_count"}, glog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < glog.size(); i++)
      chk(tag, {31'd0, glog[i]}, {31'd0, exp[i]});
  endtask

  function automatic req_t mk(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    req_t t;
    t.cmd = c; t.a = a; t.b = b;
    return t;
  endfunction

  initial begin
    logic exp_order[$];
    int   n;
    drive();
    repeat (3) step();
    reset = 1'b0;
    step();

    // single ADD on requester 0
    glog.delete();
    q0.push_back(mk(3'd0, 32'd1, 32'd2));
    drive();
    drain(40);
    chk("t1_result", result, 32'd3);
    exp_order = '{1'b0};
    chk_order("t1_order", exp_order);

    // SUB equal operands on requester 1
    q1.push_back(mk(3'd1, 32'd3, 32'd3));
    drive();
    drain(40);
    chk("t2_result", result, 32'd0);
    chk("t2_flags", {28'd0, respId, carryout, zero, overflow}, 32'b1110);

    // both requesters contend for four ops
    glog.delete();
    q0.push_back(mk(3'd2, 32'd1, 32'd1));
    q0.push_back(mk(3'd2, 32'd1, 32'd1));
    q1.push_back(mk(3'd5, 32'd0, 32'd0));
    q1.push_back(mk(3'd5, 32'd0, 32'd0));
    drive();
    drain(80);
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_order = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    chk_order("t3_order", exp_order);

    // backpressure with requester 1 waiting
    rr = 1'b0;
    q0.push_back(mk(3'd4, $urandom, $urandom));
    q1.push_back(mk(3'd7, $urandom, $urandom));
    drive();
    n = 0;
    while (!shown && n < 20) begin step(); n++; end
    chk("t4_resp_within_budget", {31'd0, n < 20}, 32'd1);
    repeat (10) step();
    rr = 1'b1;
    drive();
    drain(40);

    // reset while SLT is executing
    q0.push_back(mk(3'd3, 32'd2, 32'd3));
    drive();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (8) step();
    glog.delete();
    q0.push_back(mk(3'd0, 32'hFFFF_FFFF, 32'd1));
    q1.push_back(mk(3'd1, 32'h8000_0000, 32'd1));
    drive();
    drain(60);
    exp_order = '{1'b0, 1'b1};
    chk_order("t5_order", exp_order);

    // three-deep contention on both requesters
    glog.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(3'd0, 32'h7FFF_FFFF, 32'(i)));
      q1.push_back(mk(3'd6, 32'(i), 32'd0));
    end
    drive();
    drain(120);
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    chk_order("t6_order", exp_order);

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0 && q0.size() < 3) q0.push_back(mk(3'($urandom_range(0, 7)), a, b));
      if ($urandom_range(0, 3) == 0 && q1.size() < 3) q1.push_back(mk(3'($urandom_range(0, 7)), b, a));
      rr = ($urandom_range(0, 3) != 0);
      drive();
      step();
    end
    rr = 1'b1;
    drive();
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
